fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Fetch-stage PC generator; directly consumes the branch predictor's taken/target outputs.
//  Chooses next PC each cycle: hold, predicted target, or PC+PC_INC.
//  Tracks in-flight predicted branches in a FIFO and checks each against EX resolution.
//  On a mispredict it redirects the PC, flushes the front end and counts the event.
// PARAMETERS
//  PC_W      13  PC / target width (bits)
//  PC_INC    1   sequential PC increment
//  RESET_PC  0   PC value after reset
//  BEQ_OP    4   opcode treated as a conditional branch
//  PRED_DEPTH 4  in-flight prediction FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1     clock, all state updates on posedge
//  rst_n          in   1     asynchronous active-low reset
//  stall          in   1     hazard stall; hold PC, no FIFO push
//  if_opcode      in   6     opcode of instruction at current pc
//  pred_taken     in   1     predictor taken (valid only when if_opcode==BEQ_OP)
//  pred_target    in   PC_W  predictor target (used only when pred_taken)
//  ex_resolve     in   1     EX stage resolves the oldest in-flight branch this cycle
//  ex_taken       in   1     actual outcome (PCsrc)
//  ex_target      in   PC_W  actual branch target
//  pc             out  PC_W  current fetch PC (register)
//  flush          out  1     one-cycle pulse: kill IF/ID contents
//  mispredict     out  1     one-cycle pulse, same cycle as flush
//  fifo_full      out  1     FIFO full; front end held
//  underflow_err  out  1     sticky: ex_resolve seen with FIFO empty
//  mp_count       out  16    saturating mispredict count
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - pc=RESET_PC; flush, mispredict, fifo_full, underflow_err = 0.
//   - mp_count=0; FIFO empty; state=RUN.
//  is_br = (if_opcode==BEQ_OP).
//  FSM states
//   - RUN: normal fetch.
//   - FULL: is_br with FIFO full; pc held, no push; back to RUN once a pop frees a slot.
//     The push then occurs that cycle.
//   - REDIRECT: 1 cycle after a mispredict; pc held at recovery PC, no push; then RUN.
//  Next PC, RUN and !stall (stall freezes pc and FIFO push only):
//   - is_br & pred_taken: pc <= pred_target.
//   - otherwise: pc <= pc+PC_INC, mod 2^PC_W (0x1FFF+1 -> 0x0000).
//   - On every is_br, push {pred_taken, pred_target, pc+PC_INC} (1 cycle latency).
//  Resolution, any state, when ex_resolve & FIFO not empty:
//   - Pop head. mis = (ex_taken != head.taken) | (ex_taken & head.taken & ex_target != head.target).
//   - mis: pc <= ex_taken ? ex_target : head.fallthru.
//   - mis: FIFO cleared; flush=mispredict=1 for exactly that next cycle.
//   - mis: mp_count+1 (sticks at 0xFFFF); state -> REDIRECT.
//   - !mis: pop only.
//  Simultaneous events
//   - Mispredict overrides stall, push and FULL; a same-cycle push is discarded.
//   - Correct resolve and push in the same cycle is legal at any occupancy, including full.
//   - ex_resolve with FIFO empty: ignored, underflow_err<=1 (cleared only by reset).
//   - fifo_full = (count==PRED_DEPTH), combinational from registered count.
//   - Reset mid-operation: all state discarded immediately; no flush pulse.
// TESTING
//  1. Reset release, no branches, 5 cycles -> pc 0,1,2,3,4; flush=0; mp_count=0.
//  2. pc=0x1FFF, sequential -> pc wraps to 0x0000.
//  3. pc=5, is_br, pred_taken=1, target=0x20 -> pc=0x20 next cycle.
//     Then ex_resolve, ex_taken=1, ex_target=0x20 -> no flush, FIFO empty.
//  4. pc=5, is_br, pred_taken=0 -> pc=6. Then ex_resolve, ex_taken=1, ex_target=0x40 ->
//     pc=0x40, flush/mispredict one cycle, mp_count=1, FIFO empty, pc held 1 cycle.
//  5. Predicted taken to 0x30, resolved not-taken -> pc=fallthru 6.
//     Branch pushed the same cycle is discarded.
//  6. Four unresolved branches (PRED_DEPTH=4), fifth is_br -> fifo_full=1, pc held.
//     One correct resolve -> push, pc advances, fifo_full stays 1.
//     ex_resolve on empty FIFO -> underflow_err=1.

Source files
------------

// File: rtl/fetch_pc_if.sv
// Fetch-stage bus: front-end control and predictor inputs toward the PC unit,
// plus the PC, flush and status outputs coming back.
interface fetch_pc_if #(
    parameter int PC_W = 13
);
    logic            stall;
    logic [5:0]      if_opcode;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            ex_resolve;
    logic            ex_taken;
    logic [PC_W-1:0] ex_target;
    logic [PC_W-1:0] pc;
    logic            flush;
    logic            mispredict;
    logic            fifo_full;
    logic            underflow_err;
    logic [15:0]     mp_count;

    modport master (
        output stall, if_opcode, pred_taken, pred_target,
        output ex_resolve, ex_taken, ex_target,
        input  pc, flush, mispredict, fifo_full, underflow_err, mp_count
    );

    modport slave (
        input  stall, if_opcode, pred_taken, pred_target,
        input  ex_resolve, ex_taken, ex_target,
        output pc, flush, mispredict, fifo_full, underflow_err, mp_count
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: selects hold / predicted target / sequential PC, tracks
// in-flight predictions in a FIFO and redirects + flushes on EX mispredicts.
module fetch_pc_unit #(
    parameter int PC_W       = 13,
    parameter int PC_INC     = 1,
    parameter int RESET_PC   = 0,
    parameter int BEQ_OP     = 4,
    parameter int PRED_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_pc_if.slave  bus
);
    localparam int PTR_W = $clog2(PRED_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {RUN, FULL, REDIRECT} state_t;

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_flush;
    logic             r_mis;
    logic             r_uf;
    logic [15:0]      r_mp;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_cnt;

    logic             r_q_taken  [PRED_DEPTH];
    logic [PC_W-1:0]  r_q_target [PRED_DEPTH];
    logic [PC_W-1:0]  r_q_fall   [PRED_DEPTH];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic            w_is_br;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_mis;
    logic            w_can_push;
    logic            w_fetch;
    logic            w_blocked;
    logic            w_push;
    logic            w_advance;

    assign w_is_br    = (bus.if_opcode == 6'(BEQ_OP));
    assign w_pc_inc   = r_pc + PC_W'(PC_INC);
    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CNT_W'(PRED_DEPTH));
    assign w_pop      = bus.ex_resolve & ~w_empty;
    assign w_mis      = w_pop & ((bus.ex_taken != r_q_taken[r_rd]) |
                                 (bus.ex_taken & r_q_taken[r_rd] &
                                  (bus.ex_target != r_q_target[r_rd])));
    // A correct pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_can_push = ~w_full | w_pop;
    assign w_fetch    = (r_state != REDIRECT) & ~bus.stall & ~w_mis;
    assign w_blocked  = w_fetch & w_is_br & ~w_can_push;
    assign w_push     = w_fetch & w_is_br & w_can_push;
    assign w_advance  = w_fetch & ~w_blocked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_pc    <= PC_W'(RESET_PC);
            r_flush <= 1'b0;
            r_mis   <= 1'b0;
            r_uf    <= 1'b0;
            r_mp    <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_flush <= w_mis;
            r_mis   <= w_mis;
            if (bus.ex_resolve && w_empty)
                r_uf <= 1'b1;
            if (w_mis) begin
                r_mp    <= sat_inc16(r_mp);
                r_pc    <= bus.ex_taken ? bus.ex_target : r_q_fall[r_rd];
                r_cnt   <= '0;
                r_rd    <= '0;
                r_wr    <= '0;
                r_state <= REDIRECT;
            end else begin
                if (w_advance)
                    r_pc <= (w_is_br && bus.pred_taken) ? bus.pred_target : w_pc_inc;
                if (w_push)
                    r_wr <= r_wr + PTR_W'(1);
                if (w_pop)
                    r_rd <= r_rd + PTR_W'(1);
                r_cnt   <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
                r_state <= w_blocked ? FULL : RUN;
            end
        end
    end

    // Prediction payload is pure data; occupancy is tracked by r_cnt.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_taken[r_wr]  <= bus.pred_taken;
            r_q_target[r_wr] <= bus.pred_target;
            r_q_fall[r_wr]   <= w_pc_inc;
        end
    end

    assign bus.pc            = r_pc;
    assign bus.flush         = r_flush;
    assign bus.mispredict    = r_mis;
    assign bus.fifo_full     = w_full;
    assign bus.underflow_err = r_uf;
    assign bus.mp_count      = r_mp;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed, table-driven bench for fetch_pc_unit with hand-computed expectations.
module tb_fetch_pc_unit;
    localparam int PC_W = 13;

    logic clk;
    logic rst_n;

    fetch_pc_if #(.PC_W(PC_W)) bus ();

    fetch_pc_unit #(
        .PC_W(PC_W), .PC_INC(1), .RESET_PC(0), .BEQ_OP(4), .PRED_DEPTH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            stall;
        logic            br;
        logic            pt;
        logic [PC_W-1:0] tgt;
        logic            res;
        logic            ext;
        logic [PC_W-1:0] etgt;
        logic [PC_W-1:0] pc;
        logic            fl;
        logic            full;
        logic            uf;
        logic [15:0]     mp;
    } vec_t;

    vec_t vt[$];
    int   errs   = 0;
    int   checks = 0;

    task automatic add(input logic s, input logic br, input logic pt, input int tgt,
                       input logic res, input logic ext, input int etgt,
                       input int pc, input logic fl, input logic full,
                       input logic uf, input int mp);
        vec_t v;
        v.stall = s;   v.br = br;   v.pt = pt;   v.tgt = PC_W'(tgt);
        v.res = res;   v.ext = ext; v.etgt = PC_W'(etgt);
        v.pc = PC_W'(pc); v.fl = fl; v.full = full; v.uf = uf; v.mp = 16'(mp);
        vt.push_back(v);
    endtask

    task automatic drive(input logic s, input logic br, input logic pt, input int tgt,
                         input logic res, input logic ext, input int etgt);
        bus.stall       = s;
        bus.if_opcode   = br ? 6'd4 : 6'd5;
        bus.pred_taken  = pt;
        bus.pred_target = PC_W'(tgt);
        bus.ex_resolve  = res;
        bus.ex_taken    = ext;
        bus.ex_target   = PC_W'(etgt);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.pc, bus.flush, bus.mispredict, bus.fifo_full,
                    bus.underflow_err, bus.mp_count});
    endfunction

    function automatic logic [63:0] expv(input logic [PC_W-1:0] pc, input logic fl,
                                         input logic full, input logic uf,
                                         input logic [15:0] mp);
        return 64'({pc, fl, fl, full, uf, mp});
    endfunction

    initial begin
        //  s  br pt tgt     res ext etgt     pc      fl full uf mp
        add(0, 0, 0, 0,      0, 0, 0,      1,      0, 0, 0, 0);
        add(0, 0, 0, 0,      0, 0, 0,      2,      0, 0, 0, 0);
        add(0, 0, 0, 0,      0, 0, 0,      3,      0, 0, 0, 0);
        add(0, 0, 0, 0,      0, 0, 0,      4,      0, 0, 0, 0);
        add(0, 0, 0, 0,      0, 0, 0,      5,      0, 0, 0, 0);
        add(0, 1, 1, 'h20,   0, 0, 0,      'h20,   0, 0, 0, 0);
        add(0, 0, 0, 0,      1, 1, 'h20,   'h21,   0, 0, 0, 0);
        add(0, 1, 1, 4,      0, 0, 0,      4,      0, 0, 0, 0);
        add(0, 0, 0, 0,      1, 1, 4,      5,      0, 0, 0, 0);
        add(0, 1, 0, 'h77,   0, 0, 0,      6,      0, 0, 0, 0);
        add(0, 0, 0, 0,      1, 1, 'h40,   'h40,   1, 0, 0, 1);
        add(0, 0, 0, 0,      0, 0, 0,      'h40,   0, 0, 0, 1);
        add(0, 0, 0, 0,      0, 0, 0,      'h41,   0, 0, 0, 1);
        add(0, 1, 1, 4,      0, 0, 0,      4,      0, 0, 0, 1);
        add(0, 0, 0, 0,      1, 1, 4,      5,      0, 0, 0, 1);
        add(0, 1, 1, 'h30,   0, 0, 0,      'h30,   0, 0, 0, 1);
        add(0, 1, 1, 'h55,   1, 0, 0,      6,      1, 0, 0, 2);
        add(0, 0, 0, 0,      0, 0, 0,      6,      0, 0, 0, 2);
        add(0, 0, 0, 0,      0, 0, 0,      7,      0, 0, 0, 2);
        add(0, 1, 0, 0,      0, 0, 0,      8,      0, 0, 0, 2);
        add(0, 1, 0, 0,      0, 0, 0,      9,      0, 0, 0, 2);
        add(0, 1, 0, 0,      0, 0, 0,      10,     0, 0, 0, 2);
        add(0, 1, 0, 0,      0, 0, 0,      11,     0, 1, 0, 2);
        add(0, 1, 0, 0,      0, 0, 0,      11,     0, 1, 0, 2);
        add(0, 1, 0, 0,      0, 0, 0,      11,     0, 1, 0, 2);
        add(0, 1, 0, 0,      1, 0, 0,      12,     0, 1, 0, 2);
        add(0, 0, 0, 0,      1, 0, 0,      13,     0, 0, 0, 2);
        add(0, 0, 0, 0,      1, 0, 0,      14,     0, 0, 0, 2);
        add(0, 0, 0, 0,      1, 0, 0,      15,     0, 0, 0, 2);
        add(0, 0, 0, 0,      1, 0, 0,      16,     0, 0, 0, 2);
        add(0, 0, 0, 0,      1, 0, 0,      17,     0, 0, 1, 2);
        add(0, 0, 0, 0,      0, 0, 0,      18,     0, 0, 1, 2);
        add(0, 1, 1, 'h1FFF, 0, 0, 0,      'h1FFF, 0, 0, 1, 2);
        add(0, 0, 0, 0,      1, 1, 'h1FFF, 0,      0, 0, 1, 2);
        add(0, 0, 0, 0,      0, 0, 0,      1,      0, 0, 1, 2);
        add(0, 1, 1, 'h10,   0, 0, 0,      'h10,   0, 0, 1, 2);
        add(0, 0, 0, 0,      1, 1, 'h11,   'h11,   1, 0, 1, 3);
        add(0, 0, 0, 0,      0, 0, 0,      'h11,   0, 0, 1, 3);
        add(0, 0, 0, 0,      0, 0, 0,      'h12,   0, 0, 1, 3);
        add(1, 1, 1, 'h70,   0, 0, 0,      'h12,   0, 0, 1, 3);
        add(1, 0, 0, 0,      0, 0, 0,      'h12,   0, 0, 1, 3);
        add(0, 0, 0, 0,      0, 0, 0,      'h13,   0, 0, 1, 3);
        add(0, 1, 0, 0,      0, 0, 0,      'h14,   0, 0, 1, 3);
        add(0, 0, 0, 0,      1, 0, 0,      'h15,   0, 0, 1, 3);
        add(0, 1, 1, 'h60,   0, 0, 0,      'h60,   0, 0, 1, 3);
        add(1, 0, 0, 0,      1, 0, 0,      'h16,   1, 0, 1, 4);
        add(0, 0, 0, 0,      0, 0, 0,      'h16,   0, 0, 1, 4);
        add(0, 0, 0, 0,      0, 0, 0,      'h17,   0, 0, 1, 4);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("reset_state", outs(), expv('0, 0, 0, 0, 16'd0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release_pc0", outs(), expv('0, 0, 0, 0, 16'd0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].stall, vt[i].br, vt[i].pt, vt[i].tgt,
                  vt[i].res, vt[i].ext, vt[i].etgt);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d", i), outs(),
                expv(vt[i].pc, vt[i].fl, vt[i].full, vt[i].uf, vt[i].mp));
        end

        // Asynchronous reset mid-operation with a branch in flight.
        drive(0, 1, 1, 'h100, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_reset_branch", outs(), expv(PC_W'('h100), 0, 0, 1, 16'd4));
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_now", outs(), expv('0, 0, 0, 0, 16'd0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_seq", outs(), expv(PC_W'(1), 0, 0, 0, 16'd0));
        drive(0, 0, 0, 0, 1, 1, 'h100);
        @(posedge clk);
        #1;
        chk("post_reset_fifo_empty", outs(), expv(PC_W'(2), 0, 0, 1, 16'd0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
